vram_ctrl: RTL and testbench

- Dual-port character/pixel framebuffer and its write controller; sits directly upstream of the VGA scan-out stage.
- Scan-out presents a byte address (col + row*40, 40x30 cells) and consumes a 32-bit word; it selects the byte itself from col[1:0].
- CPU store path writes bytes or words into the buffer through a memory-mapped window.
- A hardware clear engine fills the whole buffer with a chosen pattern, one word per cycle.

---
 rtl/vram_ctrl.sv | 104 ++++++++++
 tb/tb_vram_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_ctrl.sv
// VGA framebuffer (40x30 cells, 300 words) with masked CPU stores, a registered
// scan-out read and a word-per-cycle clear engine. VRAM_CPU_READ_EN adds a CPU read port.
module vram_ctrl #(
  parameter logic [31:0] VRAM_BASE   = 32'h0000_2000,
  parameter int          DEPTH_WORDS = 300,
  parameter int          AW          = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wmask,
  input  logic        clear_req,
  input  logic [31:0] clear_data,
  output logic        busy,
  input  logic [31:0] vaddr,
  output logic [31:0] vdata,
`ifdef VRAM_CPU_READ_EN
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
`endif
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  localparam logic [31:0]   SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0]   VRAM_END = VRAM_BASE + SPAN;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  state_t        state;
  logic [AW-1:0] count;
  logic [31:0]   pattern;

  logic          in_win;
  logic          cpu_hit;
  logic          fill_we;
  logic [31:0]   cpu_off;
  logic [AW-1:0] cpu_idx;
  logic          scan_hit;
  logic [AW-1:0] scan_idx;
  logic          unused_bits;

  // Full 32-bit compares first; only then truncate to a word index.
  assign in_win    = (cpu_addr >= VRAM_BASE) && (cpu_addr < VRAM_END);
  assign cpu_hit   = cpu_we & in_win;
  assign cpu_off   = cpu_addr - VRAM_BASE;
  assign cpu_idx   = cpu_off[AW+1:2];
  assign scan_hit  = vaddr < SPAN;
  assign scan_idx  = vaddr[AW+1:2];
  assign dbg_state = state;
  assign unused_bits = ^{cpu_off[31:AW+2], cpu_off[1:0], vaddr[1:0]};

  // CPU hits steal the write port; a restart cycle writes nothing.
  assign fill_we = (state == FILL) & ~cpu_hit & ~clear_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      count   <= '0;
      pattern <= '0;
    end else if (clear_req) begin
      state   <= FILL;
      busy    <= 1'b1;
      count   <= '0;
      pattern <= clear_data;
    end else if (fill_we) begin
      if (count == LAST_IDX) begin
        state <= IDLE;
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (cpu_wmask[i]) mem[cpu_idx][8*i +: 8] <= cpu_wdata[8*i +: 8];
      end
    end else if (fill_we) begin
      mem[count] <= pattern;
    end
  end

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vdata <= '0;
    else       vdata <= scan_hit ? mem[scan_idx] : 32'h0;
  end

`ifdef VRAM_CPU_READ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_rdata <= '0;
    else       cpu_rdata <= (cpu_re & in_win) ? mem[cpu_idx] : 32'h0;
  end
`endif

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed bench for vram_ctrl: store/read vector table plus clear, stall,
// restart and mid-fill reset sequences checked against a word-array model.
module tb_vram_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wmask = '0;
  logic        clear_req = 1'b0;
  logic [31:0] clear_data = '0;
  logic        busy;
  logic [31:0] vaddr = '0;
  logic [31:0] vdata;
  logic        dbg_state;
`ifdef VRAM_CPU_READ_EN
  logic        cpu_re = 1'b0;
  logic [31:0] cpu_rdata;
`endif

  vram_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .clear_req(clear_req), .clear_data(clear_data), .busy(busy),
    .vaddr(vaddr), .vdata(vdata),
`ifdef VRAM_CPU_READ_EN
    .cpu_re(cpu_re), .cpu_rdata(cpu_rdata),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic store(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask);
    cpu_we = we; cpu_addr = addr; cpu_wdata = data; cpu_wmask = mask;
    tick();
    cpu_we = 1'b0;
    if (we && addr >= BASE && addr < BASE + 32'(4*DEPTH)) begin
      for (int i = 0; i < 4; i++)
        if (mask[i]) model[(addr - BASE) >> 2][8*i +: 8] = data[8*i +: 8];
    end
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    vaddr = addr;
    tick();
    check(name, vdata, exp);
  endtask

  task automatic scan_all(input string name);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < DEPTH; i++) begin
      vaddr = 32'(4*i);
      tick();
      check($sformatf("%s w%0d", name, i), vdata, exp_q.pop_front());
    end
  endtask

  task automatic start_clear(input logic [31:0] pat);
    clear_data = pat;
    clear_req  = 1'b1;
    tick();
    clear_req  = 1'b0;
  endtask

  // Counts post-edge samples with busy high, bounded so a stuck engine still ends.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, BASE + 32'd4,    32'hAABBCCDD, 4'b0101, 32'd4,    32'h00BB00DD};
    vecs[1]  = '{1'b1, BASE + 32'd6,    32'h11223344, 4'b1010, 32'd4,    32'h11BB33DD};
    vecs[2]  = '{1'b1, BASE,            32'h12345678, 4'b1111, 32'd0,    32'h12345678};
    vecs[3]  = '{1'b1, BASE + 32'd1196, 32'hCAFEF00D, 4'b1111, 32'd1196, 32'hCAFEF00D};
    vecs[4]  = '{1'b1, BASE + 32'd1200, 32'hFFFFFFFF, 4'b1111, 32'd1196, 32'hCAFEF00D};
    vecs[5]  = '{1'b1, BASE - 32'd4,    32'hFFFFFFFF, 4'b1111, 32'd0,    32'h12345678};
    vecs[6]  = '{1'b1, BASE + 32'd8,    32'hDEADBEEF, 4'b0000, 32'd8,    32'h00000000};
    vecs[7]  = '{1'b1, BASE + 32'd8,    32'hDEADBEEF, 4'b1000, 32'd8,    32'hDE000000};
    vecs[8]  = '{1'b1, 32'h0,           32'h99999999, 4'b1111, 32'd0,    32'h12345678};
    vecs[9]  = '{1'b0, BASE + 32'd12,   32'h77777777, 4'b1111, 32'd1200, 32'h00000000};
    vecs[10] = '{1'b0, BASE + 32'd12,   32'h77777777, 4'b1111, 32'd1330, 32'h00000000};

    #3;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset vdata", vdata, 32'h0);
    check("reset state", {31'b0, dbg_state}, 32'h0);
    reset = 1'b0;
    tick();

    start_clear(32'h0);
    wait_busy(n);
    check("clear0 cycles", 32'(n), 32'd300);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    for (int i = 0; i < 11; i++) begin
      store(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask);
      read_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Same-word store and scan read in one cycle returns the old word.
    vaddr = 32'd12;
    store(1'b1, BASE + 32'd12, 32'hA5A5A5A5, 4'b1111);
    check("collision old", vdata, 32'h0);
    read_chk("collision new", 32'd12, 32'hA5A5A5A5);

    start_clear(32'h20202020);
    check("fill busy", {31'b0, busy}, 32'h1);
    wait_busy(n);
    check("clear20 cycles", 32'(n), 32'd300);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h20202020;
    scan_all("clear20");

    // CPU hit at word 5 while the counter sits at 10 stalls the fill once.
    start_clear(32'h3C3C3C3C);
    n = 0;
    cpu_addr = BASE + 32'd20; cpu_wdata = 32'h11111111; cpu_wmask = 4'b1111;
    while (busy && n < 2000) begin
      cpu_we = (n == 10);
      n++;
      tick();
    end
    cpu_we = 1'b0;
    check("stall cycles", 32'(n), 32'd301);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h3C3C3C3C;
    model[5] = 32'h11111111;
    scan_all("stall");

    // Restart mid-fill: the second pattern covers every word.
    start_clear(32'h77777777);
    repeat (20) tick();
    start_clear(32'h88888888);
    check("restart busy", {31'b0, busy}, 32'h1);
    wait_busy(n);
    check("restart cycles", 32'(n), 32'd300);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h88888888;
    scan_all("restart");

    // Reset after 50 fill writes: words 0..49 take the new pattern only.
    vaddr = 32'd0;
    start_clear(32'h5A5A5A5A);
    repeat (50) tick();
    check("prereset vdata", vdata, 32'h5A5A5A5A);
    reset = 1'b1;
    #1;
    check("abort busy", {31'b0, busy}, 32'h0);
    check("abort vdata", vdata, 32'h0);
    check("abort state", {31'b0, dbg_state}, 32'h0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 50; i++) model[i] = 32'h5A5A5A5A;
    scan_all("abort");

    start_clear(32'h0F0F0F0F);
    wait_busy(n);
    check("refill cycles", 32'(n), 32'd300);
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0F0F0F0F;
    scan_all("refill");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
